// File: rtl/bcd_pkg.sv
// Shared definitions for the packed-BCD to binary decode path.
// Holds the FSM state encoding, digit limits and the default sizing.
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DIGIT_W       = 4;
    localparam int BCD_MAX_DIGIT = 9;
    localparam int DEF_DIGITS    = 4;
    localparam int DEF_BIN_W     = 14;

endpackage

// File: rtl/bcd_digit_mac.sv
// One decimal place-value step: acc*10 + digit, with a digit-validity flag.
// Out-of-range digits contribute zero so the accumulator keeps its place value.
module bcd_digit_mac
    import bcd_pkg::*;
#(
    parameter int BIN_W = DEF_BIN_W
) (
    input  logic [BIN_W-1:0]   i_acc,
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [BIN_W-1:0]   o_acc,
    output logic               o_digit_ok
);

    localparam int EXT_W = BIN_W + DIGIT_W;
    localparam logic [DIGIT_W-1:0] MAX_DIGIT = DIGIT_W'(BCD_MAX_DIGIT);

    logic [EXT_W-1:0] w_acc_ext;
    logic [EXT_W-1:0] w_acc_x10;
    logic [EXT_W-1:0] w_digit_ext;
    logic [EXT_W-1:0] w_sum;
    logic             w_unused_hi;

    assign o_digit_ok  = (i_digit <= MAX_DIGIT);
    assign w_acc_ext   = {{DIGIT_W{1'b0}}, i_acc};
    assign w_acc_x10   = (w_acc_ext << 3) + (w_acc_ext << 1);
    assign w_digit_ext = o_digit_ok ? {{BIN_W{1'b0}}, i_digit} : '0;
    assign w_sum       = w_acc_x10 + w_digit_ext;

    // A legal BIN_W never sets these bits; they are dropped on store.
    assign w_unused_hi = |w_sum[EXT_W-1:BIN_W];
    assign o_acc       = w_sum[BIN_W-1:0];

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to binary converter, one digit per cycle, MSD first.
// Valid/ready on both sides; result registers change only when a conversion completes.
module bcd_to_bin
    import bcd_pkg::*;
#(
    parameter int DIGITS = DEF_DIGITS,
    parameter int BIN_W  = DEF_BIN_W
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic [DIGIT_W*DIGITS-1:0] i_bcd_in,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [BIN_W-1:0]       o_bin_out,
    output logic                   o_err
);

    localparam int SR_W  = DIGIT_W * DIGITS;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SR_W-1:0]    r_sr;
    logic [BIN_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_err_acc;
    logic [BIN_W-1:0]   r_bin_out;
    logic               r_err;
    logic [BIN_W-1:0]   w_mac_acc;
    logic               w_digit_ok;
    logic               w_last;

    bcd_digit_mac #(
        .BIN_W (BIN_W)
    ) u_mac (
        .i_acc      (r_acc),
        .i_digit    (r_sr[SR_W-1 -: DIGIT_W]),
        .o_acc      (w_mac_acc),
        .o_digit_ok (w_digit_ok)
    );

    assign w_last = (r_cnt == LAST_CNT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (i_in_valid) w_state_nxt = ST_CONV;
            ST_CONV: if (w_last)     w_state_nxt = ST_DONE;
            ST_DONE: if (i_out_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sr      <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_err_acc <= 1'b0;
            r_bin_out <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_in_valid) begin
                        r_sr      <= i_bcd_in;
                        r_acc     <= '0;
                        r_cnt     <= '0;
                        r_err_acc <= 1'b0;
                    end
                end
                ST_CONV: begin
                    r_acc     <= w_mac_acc;
                    r_err_acc <= r_err_acc | ~w_digit_ok;
                    r_sr      <= r_sr << DIGIT_W;
                    r_cnt     <= r_cnt + 1'b1;
                    // Publish the final digit's result directly so DONE sees it at once.
                    if (w_last) begin
                        r_bin_out <= w_mac_acc;
                        r_err     <= r_err_acc | ~w_digit_ok;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_in_ready  = (r_state == ST_IDLE);
    assign o_out_valid = (r_state == ST_DONE);
    assign o_bin_out   = r_bin_out;
    assign o_err       = r_err;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Scoreboard bench for bcd_to_bin: expected results queued at acceptance,
// compared when the DUT hands a result over.
module tb_bcd_to_bin;

    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;

    typedef struct {
        logic [BIN_W-1:0] bin;
        logic             err;
        int               acc_cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [15:0]       bcd_in = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [BIN_W-1:0]  bin_out;
    logic              err;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   last_acc = -1;
    bit   chk_spacing = 1'b0;
    logic prev_ov = 1'b0;

    bcd_to_bin #(
        .DIGITS (DIGITS),
        .BIN_W  (BIN_W)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_bcd_in    (bcd_in),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_bin_out   (bin_out),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && !prev_ov) begin
            if (sb.size() == 0) check("unexpected_out_valid", 32'(out_valid), 32'd0);
            else                check("latency", 32'(cyc - sb[0].acc_cyc), 32'(DIGITS));
        end
        if (rst_n && out_valid && out_ready && sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("bin_out", 32'(bin_out), 32'(mon_e.bin));
            check("err", 32'(err), 32'(mon_e.err));
        end
        prev_ov = out_valid;
    end

    task automatic send(input logic [15:0] bcd, input logic [BIN_W-1:0] eb, input logic ee,
                        input bit push);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        bcd_in   = bcd;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            check("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (chk_spacing && last_acc >= 0) check("spacing", 32'(cyc - last_acc), 32'(DIGITS + 2));
        last_acc = cyc;
        if (push) sb.push_back('{eb, ee, cyc});
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        logic [15:0]      rb;
        logic [BIN_W-1:0] rv;
        int               d;
        int               n;
        bit               seen;

        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_bin_out", 32'(bin_out), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;

        send(16'h1234, 14'd1234, 1'b0, 1'b1);
        drain();
        send(16'h9999, 14'd9999, 1'b0, 1'b1);
        send(16'h0000, 14'd0,    1'b0, 1'b1);
        send(16'h12A4, 14'd1204, 1'b1, 1'b1);
        send(16'h0007, 14'd7,    1'b0, 1'b1);
        drain();

        // Consumer stalls: result must hold and new input must be refused.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(16'h0315, 14'd315, 1'b0, 1'b1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("hold_reach_done", 32'(out_valid), 32'd1);
        repeat (10) begin
            @(negedge clk);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_bin_out", 32'(bin_out), 32'd315);
            check("hold_err", 32'(err), 32'd0);
            in_valid = 1'b1;
            bcd_in   = 16'($urandom);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("release_in_ready", 32'(in_ready), 32'd1);
        send(16'h0860, 14'd860, 1'b0, 1'b1);
        drain();

        // Reset in the second CONV cycle abandons the word.
        send(16'h5678, 14'd5678, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_bin_out", 32'(bin_out), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen |= out_valid;
        end
        check("midrst_no_result", 32'(seen), 32'd0);
        send(16'h0042, 14'd42, 1'b0, 1'b1);
        drain();

        chk_spacing = 1'b1;
        last_acc    = -1;
        for (int w = 0; w < 16; w++) begin
            rb = '0;
            rv = '0;
            for (int k = 3; k >= 0; k--) begin
                d = int'($urandom_range(0, 9));
                rb[4*k +: 4] = 4'(d);
                rv = BIN_W'(rv * 10 + d);
            end
            send(rb, rv, 1'b0, 1'b1);
        end
        chk_spacing = 1'b0;
        drain();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
